// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian bytes into instruction words,
// writes them to program memory at sequential addresses and holds the CPU in reset meanwhile.
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 7,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic [ADD_WIDTH:0]    word_count,
  output logic                  overflow
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);

  localparam logic [ADD_WIDTH:0]   DEPTH    = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [ADD_WIDTH:0]   WC_ONE   = {{ADD_WIDTH{1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  byte_idx;
  logic [DATA_WIDTH-1:0] asm_reg;
  logic [DATA_WIDTH-1:0] asm_merged;
  logic                  accept;
  logic                  last_byte;
  logic                  flush_write;

  // Ready is derived only from registered state, so there is no input-to-ready path.
  assign byte_ready = (state == S_LOAD) && (word_count < DEPTH);
  assign loading    = (state == S_LOAD) || (state == S_FLUSH);
  assign accept     = byte_valid && byte_ready;
  assign last_byte  = accept && (byte_idx == IDX_LAST);

  // A partial word (including a byte taken in the load_end cycle) is written on entry to FLUSH.
  assign flush_write = load_end && (accept ? !last_byte : (byte_idx != '0));

  // The assembly register is cleared after every full word, so unfilled upper bytes read as zero.
  always_comb begin
    asm_merged = asm_reg;
    if (accept) begin
      asm_merged[int'(byte_idx) * BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pm_wr_en   <= 1'b0;
      pm_addr    <= '0;
      pm_wr_data <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      cpu_rst    <= 1'b1;
      byte_idx   <= '0;
      asm_reg    <= '0;
    end else begin
      pm_wr_en <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            state      <= S_LOAD;
            cpu_rst    <= 1'b1;
            pm_addr    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            byte_idx   <= '0;
            asm_reg    <= '0;
          end
        end

        S_LOAD: begin
          cpu_rst <= 1'b1;
          if (accept) begin
            if (last_byte) begin
              byte_idx <= '0;
              asm_reg  <= '0;
            end else begin
              byte_idx <= byte_idx + IDX_ONE;
              asm_reg  <= asm_merged;
            end
          end
          if (byte_valid && !byte_ready) begin
            overflow <= 1'b1;
          end
          // The write address is the number of words already written in this load.
          if (last_byte || flush_write) begin
            pm_wr_en   <= 1'b1;
            pm_addr    <= word_count[ADD_WIDTH-1:0];
            pm_wr_data <= asm_merged;
            word_count <= word_count + WC_ONE;
          end
          if (load_end) begin
            state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          state    <= S_RUN;
          cpu_rst  <= 1'b0;
          byte_idx <= '0;
          asm_reg  <= '0;
        end

        default: begin
          state   <= S_IDLE;
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; expected writes come from a
// byte-list model that groups accepted bytes into little-endian words.
module tb_program_loader;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_end = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_ready;
  logic        pm_wr_en;
  logic [6:0]  pm_addr;
  logic [31:0] pm_wr_data;
  logic        cpu_rst;
  logic        loading;
  logic [7:0]  word_count;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit in_run = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    int          cycle;
    logic        crst;
  } wr_t;

  wr_t        wr_log[$];
  logic [7:0] stim[$];

  program_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pm_wr_en(pm_wr_en), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
    .cpu_rst(cpu_rst), .loading(loading), .word_count(word_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe is logged with the cycle it appeared in and the CPU reset level.
  always @(negedge clk) begin
    if (pm_wr_en === 1'b1) wr_log.push_back('{pm_addr, pm_wr_data, cyc, cpu_rst});
  end

  task automatic applyStimulus(input logic ls, input logic le, input logic bv, input logic [7:0] b);
    @(negedge clk);
    load_start = ls;
    load_end   = le;
    byte_valid = bv;
    byte_in    = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic runLoad(input string name, input bit toggle, input bit end_with_last);
    logic [7:0]  acc[$];
    int          acc_cyc[$];
    int          n = stim.size();
    int          end_cyc = 0;
    bit          exp_ovf = 0;
    bit          exp_ready;
    int          n_words;
    int          n_cmp;
    int          exp_cyc;
    logic [31:0] exp_word;
    wr_log.delete();
    // A byte offered alongside load_start must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom));
    checkOutput({name, " start_ready"}, byte_ready, 0);
    checkOutput({name, " start_cpu_rst"}, cpu_rst, in_run ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, end_with_last && (i == n - 1), 1'b1, stim[i]);
      if (i == 0) begin
        checkOutput({name, " load_cpu_rst"}, cpu_rst, 1);
        checkOutput({name, " load_loading"}, loading, 1);
        checkOutput({name, " load_word_count"}, word_count, 0);
        checkOutput({name, " load_overflow"}, overflow, 0);
      end
      exp_ready = (acc.size() < 4 * DEPTH);
      checkOutput({name, " byte_ready"}, byte_ready, exp_ready);
      if (exp_ready) begin
        acc.push_back(stim[i]);
        acc_cyc.push_back(cyc);
      end else begin
        exp_ovf = 1;
      end
      if (end_with_last && i == n - 1) end_cyc = cyc;
    end
    if (!end_with_last) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      end_cyc = cyc;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({name, " flush_loading"}, loading, 1);
    checkOutput({name, " flush_cpu_rst"}, cpu_rst, 1);
    checkOutput({name, " flush_ready"}, byte_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({name, " run_cpu_rst"}, cpu_rst, 0);
    checkOutput({name, " run_loading"}, loading, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    n_words = (acc.size() + 3) / 4;
    checkOutput({name, " write_count"}, wr_log.size(), n_words);
    n_cmp = (wr_log.size() < n_words) ? wr_log.size() : n_words;
    for (int w = 0; w < n_cmp; w++) begin
      exp_word = 32'h0;
      for (int j = 0; j < 4; j++) begin
        if (4 * w + j < acc.size()) exp_word |= 32'(acc[4 * w + j]) << (8 * j);
      end
      exp_cyc = (4 * w + 3 < acc.size()) ? acc_cyc[4 * w + 3] + 1 : end_cyc + 1;
      checkOutput($sformatf("%s wr%0d_addr", name, w), wr_log[w].addr, w % DEPTH);
      checkOutput($sformatf("%s wr%0d_data", name, w), wr_log[w].data, exp_word);
      checkOutput($sformatf("%s wr%0d_cycle", name, w), wr_log[w].cycle, exp_cyc);
      checkOutput($sformatf("%s wr%0d_cpu_rst", name, w), wr_log[w].crst, 1);
    end
    checkOutput({name, " word_count"}, word_count, n_words);
    checkOutput({name, " overflow"}, overflow, exp_ovf);
    in_run = 1;
  endtask

  task automatic fillRandom(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset pm_wr_en", pm_wr_en, 0);
    checkOutput("reset pm_addr", pm_addr, 0);
    checkOutput("reset pm_wr_data", pm_wr_data, 0);
    checkOutput("reset word_count", word_count, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset byte_ready", byte_ready, 0);
    checkOutput("reset loading", loading, 0);
    checkOutput("reset cpu_rst", cpu_rst, 1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);
    checkOutput("idle byte_ready", byte_ready, 0);

    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    runLoad("two_words", 1'b0, 1'b0);
    stim = '{8'hAA, 8'hBB};
    runLoad("partial", 1'b0, 1'b0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    runLoad("toggled", 1'b1, 1'b0);
    fillRandom(8);
    runLoad("end_on_4th", 1'b0, 1'b1);
    fillRandom($urandom_range(1, 40));
    runLoad("rand_len", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    fillRandom(4 * DEPTH + 4);
    runLoad("full", 1'b0, 1'b0);
    fillRandom(6);
    runLoad("after_full", 1'b0, 1'b1);

    // Reset in the middle of the third word, with load_end and a byte pending.
    wr_log.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checkOutput("midrst cpu_rst", cpu_rst, 1);
    checkOutput("midrst loading", loading, 0);
    checkOutput("midrst byte_ready", byte_ready, 0);
    checkOutput("midrst word_count", word_count, 0);
    checkOutput("midrst pm_wr_en", pm_wr_en, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("midrst write_count", wr_log.size(), 2);
    in_run = 0;

    fillRandom(12);
    runLoad("from_idle", 1'b0, 1'b0);
    fillRandom(5);
    runLoad("from_run", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
